processing_element_ws: RTL and testbench
========================================

# processing_element_ws

Weight-stationary processing element (PE), the unit cell of a systolic-array matrix multiplier. Each PE holds one weight, accepts activations from the west and partial sums from the north, and forwards registered activations east and registered partial sums plus control south. A column of PEs is preloaded with weights through the partial-sum path, then streams multiply-accumulate (MAC) results.

## Interface
- WORD_WIDTH, default 8: width of activations and weights. Partial sums are 4*WORD_WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-high reset (1 = reset), despite the suffix. Asserting it clears all state immediately; deasserting it resumes operation at the next rising clk edge.
- control  input  2  operation select: 00 idle, 01 load weight, 10 compute, 11 reserved (behaves as idle).
- a_in  input  WORD_WIDTH  signed activation from the west neighbour.
- d_in  input  4*WORD_WIDTH  signed partial sum from the north neighbour, or a weight in load mode.
- control_out  output  2  registered copy of control, driving the south neighbour.
- a_out  output  WORD_WIDTH  registered activation, driving the east neighbour.
- d_out  output  4*WORD_WIDTH  registered partial sum or weight, driving the south neighbour.

## Operation
- State: weight register (WORD_WIDTH), control_out, a_out, d_out registers. All outputs come directly from registers.
- Idle (00 or 11):
  - weight, a_out and d_out hold their values.
  - control_out <= control.
- Load (01): weight enters via d_in and shifts down the column.
  - weight <= d_in[WORD_WIDTH-1:0].
  - d_out <= previous weight, sign-extended to 4*WORD_WIDTH.
  - a_out <= 0.
  - control_out <= 01.
  - N load cycles fill an N-deep column. The first value presented ends in the bottom PE.
- Compute (10):
  - d_out <= d_in + sext(a_in) * sext(weight).
  - Arithmetic is two's-complement signed. The product is 2*WORD_WIDTH bits, sign-extended to 4*WORD_WIDTH. The sum wraps modulo 2^(4*WORD_WIDTH); there is no saturation and no overflow flag.
  - a_out <= a_in.
  - control_out <= 10.
  - weight holds.
- The upper d_in bits, d_in[4*WORD_WIDTH-1:WORD_WIDTH], are ignored in load mode.

## Timing
- Reset values: weight = 0, control_out = 00, a_out = 0, d_out = 0. Reset has priority over every control value.
- Latency is 1 cycle for every output: the value computed from inputs sampled at edge k is visible after edge k.
- There is no handshake and no stall; the PE acts on control every cycle.
- Mode changes take effect on the same edge. A compute cycle directly after a load cycle uses the weight just written.
- Reset asserted mid-compute clears all registers, including the weight. Weights must be reloaded after reset.
- Inputs must be stable around the rising edge. Only X-free values are required to produce defined outputs.

## Structure
- Shared package (pe_pkg) holds:
  - control encodings CTRL_IDLE = 2'b00, CTRL_LOAD = 2'b01, CTRL_COMPUTE = 2'b10, CTRL_RSVD = 2'b11;
  - the partial-sum width factor (4).
- One sub-module, pe_mac: combinational signed multiply-add computing d_in + a*w at 4*WORD_WIDTH width. The PE wraps it with the mode decode and registers.
- Parameterised throughout by WORD_WIDTH; no hard-coded 8 or 32.

## Test plan
- Reset: assert reset_n=1 with clk stopped -> all outputs 0 immediately; deassert -> outputs stay 0 under idle.
- Weight load chain: control=01, d_in=3, 4, 5 on three edges -> d_out = 0, 3, 4 after each edge; weight=5; control_out=01; a_out=0.
- Compute: after the load, control=10, d_in=4, a_in=2 -> after next edge d_out=14, a_out=2, control_out=10; stable over 3 repeated cycles.
- Signed math (WORD_WIDTH=8): weight=-3 (0xFD), a_in=7, d_in=100 -> d_out=79. Also weight=-128, a_in=-128, d_in=0 -> d_out=16384.
- Wrap-around: weight=1, a_in=1, d_in=0xFFFFFFFF -> d_out=0. Then control=11 -> all outputs hold, control_out=11.
- Reset mid-operation: reset asserted during compute -> outputs and weight 0 asynchronously; then compute with a_in=5, d_in=7 without reloading -> d_out=7.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary processing element:
// control encodings and the partial-sum width factor.
package pe_pkg;

    localparam int PSUM_FACTOR = 4;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'b00,
        CTRL_LOAD    = 2'b01,
        CTRL_COMPUTE = 2'b10,
        CTRL_RSVD    = 2'b11
    } ctrl_e;

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add: y = d + a*w, wrapping at PSUM_FACTOR*WORD_WIDTH bits.
module pe_mac
    import pe_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic signed [WORD_WIDTH-1:0]             a,
    input  logic signed [WORD_WIDTH-1:0]             w,
    input  logic signed [PSUM_FACTOR*WORD_WIDTH-1:0] d,
    output logic signed [PSUM_FACTOR*WORD_WIDTH-1:0] y
);

    localparam int PROD_W = 2 * WORD_WIDTH;
    localparam int PSUM_W = PSUM_FACTOR * WORD_WIDTH;

    logic signed [PROD_W-1:0] prod;
    logic signed [PSUM_W-1:0] prod_ext;

    assign prod     = a * w;
    assign prod_ext = {{(PSUM_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign y        = d + prod_ext;

endmodule

// File: rtl/processing_element_ws.sv
// Weight-stationary systolic PE: holds one weight, shifts weights south in load
// mode and forwards activation east / partial sum south in compute mode.
module processing_element_ws
    import pe_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [1:0]                               control,
    input  logic signed [WORD_WIDTH-1:0]             a_in,
    input  logic signed [PSUM_FACTOR*WORD_WIDTH-1:0] d_in,
    output logic [1:0]                               control_out,
    output logic signed [WORD_WIDTH-1:0]             a_out,
    output logic signed [PSUM_FACTOR*WORD_WIDTH-1:0] d_out
);

    localparam int PSUM_W = PSUM_FACTOR * WORD_WIDTH;

    logic signed [WORD_WIDTH-1:0] weight_p0;
    logic signed [PSUM_W-1:0]     mac_sum;
    logic signed [PSUM_W-1:0]     weight_ext;

    pe_mac #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_mac (
        .a (a_in),
        .w (weight_p0),
        .d (d_in),
        .y (mac_sum)
    );

    assign weight_ext = {{(PSUM_W-WORD_WIDTH){weight_p0[WORD_WIDTH-1]}}, weight_p0};

    // Output register stage; reset is named _n but is active-high.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            weight_p0   <= '0;
            control_out <= CTRL_IDLE;
            a_out       <= '0;
            d_out       <= '0;
        end else begin
            control_out <= control;
            case (ctrl_e'(control))
                CTRL_LOAD: begin
                    weight_p0 <= d_in[WORD_WIDTH-1:0];
                    d_out     <= weight_ext;
                    a_out     <= '0;
                end
                CTRL_COMPUTE: begin
                    d_out <= mac_sum;
                    a_out <= a_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_processing_element_ws.sv
// Directed table-driven bench for processing_element_ws (WORD_WIDTH = 8).
module tb_processing_element_ws;

    logic        clk;
    logic        clk_en;
    logic        reset_n;
    logic [1:0]  control;
    logic [7:0]  a_in;
    logic [31:0] d_in;
    logic [1:0]  control_out;
    logic [7:0]  a_out;
    logic [31:0] d_out;

    int checks;
    int errors;

    processing_element_ws #(
        .WORD_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .control     (control),
        .a_in        (a_in),
        .d_in        (d_in),
        .control_out (control_out),
        .a_out       (a_out),
        .d_out       (d_out)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  ctrl;
        logic [7:0]  a;
        logic [31:0] d;
        logic [1:0]  ec;
        logic [7:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
        control = c;
        a_in    = a;
        d_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ec,
                           input logic [7:0] ea, input logic [31:0] ed);
        chk({tag, "_ctrl"}, {30'd0, control_out}, {30'd0, ec});
        chk({tag, "_a"},    {24'd0, a_out},       {24'd0, ea});
        chk({tag, "_d"},    d_out,                ed);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_en  = 1'b0;
        reset_n = 1'b0;
        control = 2'b00;
        a_in    = '0;
        d_in    = '0;

        //            ctrl   a       d              ec     ea      ed
        vecs[0]  = '{2'b01, 8'h00, 32'd3,         2'b01, 8'h00, 32'd0};
        vecs[1]  = '{2'b01, 8'h00, 32'd4,         2'b01, 8'h00, 32'd3};
        vecs[2]  = '{2'b01, 8'h00, 32'd5,         2'b01, 8'h00, 32'd4};
        vecs[3]  = '{2'b10, 8'd2,  32'd4,         2'b10, 8'd2,  32'd14};
        vecs[4]  = '{2'b10, 8'd2,  32'd4,         2'b10, 8'd2,  32'd14};
        vecs[5]  = '{2'b10, 8'd2,  32'd4,         2'b10, 8'd2,  32'd14};
        vecs[6]  = '{2'b01, 8'h33, 32'h0000_00FD, 2'b01, 8'h00, 32'd5};
        vecs[7]  = '{2'b10, 8'd7,  32'd100,       2'b10, 8'd7,  32'd79};
        vecs[8]  = '{2'b01, 8'h00, 32'h0000_0080, 2'b01, 8'h00, 32'hFFFF_FFFD};
        vecs[9]  = '{2'b10, 8'h80, 32'd0,         2'b10, 8'h80, 32'd16384};
        vecs[10] = '{2'b01, 8'h00, 32'd1,         2'b01, 8'h00, 32'hFFFF_FF80};
        vecs[11] = '{2'b10, 8'd1,  32'hFFFF_FFFF, 2'b10, 8'd1,  32'd0};
        vecs[12] = '{2'b11, 8'd9,  32'd123,       2'b11, 8'd1,  32'd0};
        vecs[13] = '{2'b00, 8'd3,  32'd55,        2'b00, 8'd1,  32'd0};
        vecs[14] = '{2'b01, 8'd6,  32'hABCD_EF02, 2'b01, 8'h00, 32'd1};
        vecs[15] = '{2'b10, 8'hFB, 32'hFFFF_FFFF, 2'b10, 8'hFB, 32'hFFFF_FFF5};
        vecs[16] = '{2'b10, 8'd127, 32'h7FFF_FFFF, 2'b10, 8'd127, 32'h8000_00FD};

        // Asynchronous reset with the clock stopped.
        #3;
        reset_n = 1'b1;
        #1;
        chk_all("reset_async", 2'b00, 8'h00, 32'd0);
        #2;
        reset_n = 1'b0;
        clk_en  = 1'b1;
        step(2'b00, 8'd0, 32'd0);
        step(2'b00, 8'd0, 32'd0);
        chk_all("reset_idle", 2'b00, 8'h00, 32'd0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].ctrl, vecs[i].a, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ea, vecs[i].ed);
        end

        // Reset mid-compute, then compute without reloading the weight.
        step(2'b01, 8'd0, 32'd9);
        step(2'b10, 8'd3, 32'd1);
        chk_all("pre_reset", 2'b10, 8'd3, 32'd28);
        #1;
        reset_n = 1'b1;
        #1;
        chk_all("mid_reset", 2'b00, 8'h00, 32'd0);
        #1;
        reset_n = 1'b0;
        step(2'b10, 8'd5, 32'd7);
        chk_all("post_reset_compute", 2'b10, 8'd5, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
